multdiv_ctrl: RTL and testbench



---
 rtl/multdiv_ctrl.sv | 170 +++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// HI/LO multiply/divide sequencer: counter-timed multiply, restoring divide, pipeline stall.
// Optional MULTDIV_DIV0_FAST_EN: divide by zero completes in one cycle (hi=a, lo=all ones).
module multdiv_ctrl #(
    parameter int MUL_LAT   = 3,
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        is_mul,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        ready,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hilo_we,
    output logic        gpr_we
);

    // state | meaning
    // IDLE  | waiting for start, ready=1
    // MUL   | product settling, counter timing MUL_LAT
    // DIV   | one restoring step per cycle
    // FIX   | sign correction of quotient/remainder
    // DONE  | result on hi/lo, one-cycle done pulse
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    localparam int CW      = 6;
    localparam int MUL_PRE = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    a_q, b_q;
    logic           sgn_q, is_mul_q;
    logic [31:0]    rem, quo, dvs;
    logic           neg_q, neg_r;

    logic [32:0]    rem_sh;
    logic [33:0]    trial;
    logic           keep;
    logic [31:0]    rem_nxt, quo_nxt;
    logic           acc_mul, acc_sgn_div;

    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic [63:0] xe, ye;
        xe = sgn ? {{32{x[31]}}, x} : {32'd0, x};
        ye = sgn ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    always_comb begin
        rem_sh  = {rem, quo[31]};
        trial   = {1'b0, rem_sh} - {2'b00, dvs};
        keep    = ~trial[33];
        rem_nxt = keep ? trial[31:0] : rem_sh[31:0];
        quo_nxt = {quo[30:0], keep};
    end

    // is_mul always routes to the signed multiplier, whatever op says
    assign acc_mul     = is_mul | ~op[1];
    assign acc_sgn_div = ~op[0];

    assign ready   = (state == S_IDLE);
    assign stall   = (start & ~flush & (state == S_IDLE)) |
                     (state == S_MUL) | (state == S_DIV) | (state == S_FIX);
    assign hilo_we = done & ~is_mul_q & ~flush;
    assign gpr_we  = done &  is_mul_q & ~flush;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            is_mul_q <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        is_mul_q <= is_mul;
                        if (acc_mul) begin
                            sgn_q <= acc_sgn_div | is_mul;
                            cnt   <= CW'(MUL_PRE);
                            if (MUL_LAT <= 1) begin
                                {hi, lo} <= mul64(a, b, acc_sgn_div | is_mul);
                                done     <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                state <= S_MUL;
                            end
                        end else begin
                            sgn_q <= acc_sgn_div;
                            rem   <= '0;
                            quo   <= (acc_sgn_div && a[31]) ? (~a + 32'd1) : a;
                            dvs   <= (acc_sgn_div && b[31]) ? (~b + 32'd1) : b;
                            neg_q <= acc_sgn_div & (a[31] ^ b[31]);
                            neg_r <= acc_sgn_div & a[31];
                            cnt   <= CW'(DIV_STEPS - 1);
`ifdef MULTDIV_DIV0_FAST_EN
                            if (b == 32'd0) begin
                                hi    <= a;
                                lo    <= 32'hFFFF_FFFF;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                state <= S_DIV;
                            end
`else
                            state <= S_DIV;
`endif
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        {hi, lo} <= mul64(a_q, b_q, sgn_q);
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    lo    <= neg_q ? (~quo + 32'd1) : quo;
                    hi    <= neg_r ? (~rem + 32'd1) : rem;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Randomized bench for multdiv_ctrl against an arithmetic reference model.
module tb_multdiv_ctrl;
    localparam int MUL_LAT   = 3;
    localparam int DIV_STEPS = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        is_mul = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        ready, stall, done, hilo_we, gpr_we;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    bit          last_valid = 1'b1;

    multdiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_STEPS(DIV_STEPS)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .is_mul(is_mul),
        .a(a), .b(b), .flush(flush), .ready(ready), .stall(stall), .done(done),
        .hi(hi), .lo(lo), .hilo_we(hilo_we), .gpr_we(gpr_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic and truncating division.
    task automatic model(input logic [1:0] o, input logic m, input logic [31:0] x,
                         input logic [31:0] y, output logic [31:0] eh, output logic [31:0] el,
                         output int lat, output bit known);
        longint      sx, sy, q, r;
        logic [63:0] p;
        known = 1'b1;
        if (m || !o[1]) begin
            if (m || !o[0]) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = 64'(sx * sy);
            end else begin
                p = {32'd0, x} * {32'd0, y};
            end
            eh  = p[63:32];
            el  = p[31:0];
            lat = MUL_LAT;
        end else begin
            lat = DIV_STEPS + 2;
            if (y == 32'd0) begin
                eh = x;
                el = 32'hFFFF_FFFF;
                known = o[0];
`ifdef MULTDIV_DIV0_FAST_EN
                lat   = 1;
                known = 1'b1;
`endif
            end else if (!o[0]) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                q  = sx / sy;
                r  = sx % sy;
                p  = 64'(q);
                el = p[31:0];
                p  = 64'(r);
                eh = p[31:0];
            end else begin
                el = x / y;
                eh = x % y;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic m, input logic [31:0] x,
                          input logic [31:0] y, input bit flush_done);
        logic [31:0] eh, el;
        int lat, cyc;
        bit known;
        model(o, m, x, y, eh, el, lat, known);
        @(negedge clk);
        op = o; is_mul = m; a = x; b = y; start = 1'b1;
        #1;
        check("ready_c0", ready, 1);
        check("stall_c0", stall, 1);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom); is_mul = 1'($urandom);
        cyc = 1;
        while (!done && cyc < 100) begin
            check("stall_busy", stall, 1);
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, lat);
        if (known) begin
            check("hi", hi, eh);
            check("lo", lo, el);
        end
        if (flush_done) begin
            flush = 1'b1;
            #1;
            check("done_flushed", done, 1);
            check("hilo_we_flushed", hilo_we, 0);
            check("gpr_we_flushed", gpr_we, 0);
        end else begin
            check("hilo_we", hilo_we, !m);
            check("gpr_we", gpr_we, m);
            check("stall_done", stall, 0);
        end
        @(negedge clk);
        flush = 1'b0;
        check("ready_after", ready, 1);
        check("done_after", done, 0);
        last_hi = eh; last_lo = el; last_valid = known;
    endtask

    // Start a DIV, then flush (kind 0) or reset (kind 1) during cycle k.
    task automatic abort_div(input int kind, input int k);
        int seen;
        @(negedge clk);
        op = 2'b10; is_mul = 1'b0; a = $urandom; b = $urandom | 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < k; c++) @(negedge clk);
        if (kind == 0) flush = 1'b1; else resetn = 1'b0;
        @(negedge clk);
        flush = 1'b0; resetn = 1'b1;
        if (kind == 1) begin last_hi = '0; last_lo = '0; last_valid = 1'b1; end
        check("abort_ready", ready, 1);
        check("abort_stall", stall, 0);
        check("abort_done", done, 0);
        if (last_valid) begin
            check("abort_hi", hi, last_hi);
            check("abort_lo", lo, last_lo);
        end
        seen = 0;
        for (int c = 0; c < DIV_STEPS + 8; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic        rm;
        logic [31:0] ra, rb;
        int          seen;

        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_hilo_we", hilo_we, 0);
        check("rst_gpr_we", gpr_we, 0);
        resetn = 1'b1;

        run_op(2'b00, 1'b0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b11, 1'b0, 32'd100, 32'd7, 1'b0);
        run_op(2'b00, 1'b1, 32'd6, 32'd7, 1'b0);
        run_op(2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b11, 1'b0, 32'd5, 32'd0, 1'b0);
        run_op(2'b01, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        abort_div(0, 10);
        abort_div(1, 5);

        // start together with flush in IDLE is not accepted
        @(negedge clk);
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        #1;
        check("flush_start_stall", stall, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_ready", ready, 1);
        seen = 0;
        for (int c = 0; c < MUL_LAT + 3; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("flush_start_no_done", seen, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            rm = ($urandom_range(0, 3) == 0);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(ro, rm, ra, rb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1, "timeout");
    end
endmodule
